// File: rtl/regfile_pkg.sv
// Constants shared by the register file and the C-port destination selector.
package regfile_pkg;

  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned DATA_W    = 32;

  localparam logic [REG_IDX_W-1:0] REG_LR = 4'd14;
  localparam logic [REG_IDX_W-1:0] REG_PC = 4'd15;

endpackage

// File: rtl/register_file_c_if.sv
// Write-back, read-port and PC signals between the datapath and the register file.
interface register_file_c_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W
);

  logic [REG_IDX_W-1:0] c_addr;
  logic [DATA_W-1:0]    c_data;
  logic                 c_we;
  logic [REG_IDX_W-1:0] a_addr;
  logic [REG_IDX_W-1:0] b_addr;
  logic                 pc_inc;
  logic [DATA_W-1:0]    a_data;
  logic [DATA_W-1:0]    b_data;
  logic [DATA_W-1:0]    pc_out;
  logic                 lr_written;

  modport master (
    output c_addr, c_data, c_we, a_addr, b_addr, pc_inc,
    input  a_data, b_data, pc_out, lr_written
  );

  modport slave (
    input  c_addr, c_data, c_we, a_addr, b_addr, pc_inc,
    output a_data, b_data, pc_out, lr_written
  );

endinterface

// File: rtl/dec4to16.sv
// One-hot decode of the C-port destination index, gated by the write enable.
module dec4to16
  import regfile_pkg::*;
(
  input  logic [REG_IDX_W-1:0] addr,
  input  logic                 en,
  output logic [NUM_REGS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/register_file_c.sv
// 16-entry register file: R0..R14 general purpose, R15 is the program counter.
// Two combinational read ports with write-through bypass from the C port.
module register_file_c
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned RESET_PC = 0
)(
  input  logic               clk,
  input  logic               reset,
  register_file_c_if.slave   bus
);

  localparam int unsigned NUM_GP = NUM_REGS - 1;

  logic [NUM_REGS-1:0] we;
  logic [DATA_W-1:0]   gp [NUM_GP];
  logic [DATA_W-1:0]   pc;
  logic                lr_written;
  logic [DATA_W-1:0]   stored [NUM_REGS];

  dec4to16 u_dec (
    .addr   (bus.c_addr),
    .en     (bus.c_we),
    .onehot (we)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_GP; i++) gp[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_GP; i++) begin
        if (we[i]) gp[i] <= bus.c_data;
      end
    end
  end

  // A direct write to R15 (branch / link-load) wins over the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= DATA_W'(RESET_PC);
      lr_written <= 1'b0;
    end else begin
      if (we[REG_PC])   pc <= bus.c_data;
      else if (bus.pc_inc) pc <= pc + DATA_W'(PC_STEP);
      lr_written <= we[REG_LR];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_GP; i++) stored[i] = gp[i];
    stored[REG_PC] = pc;
  end

  // Pending writes forward to the read ports; the PC increment does not.
  always_comb begin
    bus.a_data = stored[bus.a_addr];
    bus.b_data = stored[bus.b_addr];
    if (bus.c_we && (bus.a_addr == bus.c_addr)) bus.a_data = bus.c_data;
    if (bus.c_we && (bus.b_addr == bus.c_addr)) bus.b_data = bus.c_data;
  end

  assign bus.pc_out     = pc;
  assign bus.lr_written = lr_written;

endmodule

// File: tb/tb_register_file_c.sv
// Directed bench for register_file_c with a behavioural reference model.
module tb_register_file_c;
  import regfile_pkg::*;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  register_file_c_if #(.DATA_W(DW)) bus ();

  register_file_c #(.DATA_W(DW), .PC_STEP(4), .RESET_PC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register contents and link-written flag.
  logic [DW-1:0] m [16];
  logic          m_lr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m[i] = '0;
      m_lr = 1'b0;
    end else begin
      m_lr = bus.c_we && (bus.c_addr == 4'd14);
      if (bus.c_we && bus.c_addr == 4'd15) m[15] = bus.c_data;
      else begin
        if (bus.pc_inc) m[15] = m[15] + 32'd4;
        if (bus.c_we) m[bus.c_addr] = bus.c_data;
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Every falling edge: compare all outputs against the model.
  always @(negedge clk) begin
    logic [DW-1:0] ea, eb;
    ea = (bus.c_we && bus.a_addr == bus.c_addr) ? bus.c_data : m[bus.a_addr];
    eb = (bus.c_we && bus.b_addr == bus.c_addr) ? bus.c_data : m[bus.b_addr];
    chk("model_a_data", bus.a_data, ea);
    chk("model_b_data", bus.b_data, eb);
    chk("model_pc_out", bus.pc_out, m[15]);
    chk("model_lr_written", DW'(bus.lr_written), DW'(m_lr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.c_addr = '0; bus.c_data = '0; bus.c_we = 1'b0;
    bus.a_addr = 4'd5; bus.b_addr = 4'd15; bus.pc_inc = 1'b0;
    repeat (2) tick();
    chk("reset_a", bus.a_data, 32'h0);
    chk("reset_b_r15", bus.b_data, 32'h0);
    chk("reset_pc", bus.pc_out, 32'h0);
    chk("reset_lr", DW'(bus.lr_written), 32'h0);
    reset = 1'b0;
    tick();

    // Bypass of a same-cycle write, then storage read
    bus.c_addr = 4'd3; bus.c_data = 32'hDEADBEEF; bus.c_we = 1'b1; bus.a_addr = 4'd3;
    #1 chk("bypass_r3", bus.a_data, 32'hDEADBEEF);
    tick();
    bus.c_we = 1'b0;
    #1 chk("stored_r3", bus.a_data, 32'hDEADBEEF);

    // PC increment
    bus.pc_inc = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("pc_inc", bus.pc_out, 32'(4 * k));
    end
    bus.pc_inc = 1'b0; bus.a_addr = 4'd15;
    #1 chk("read_r15", bus.a_data, 32'd12);

    // Branch overrides increment; pending PC write is forwarded
    bus.pc_inc = 1'b1; bus.c_we = 1'b1; bus.c_addr = 4'd15; bus.c_data = 32'h100;
    #1 chk("bypass_r15", bus.a_data, 32'h100);
    tick();
    chk("pc_branch", bus.pc_out, 32'h100);
    bus.c_we = 1'b0;
    tick();
    chk("pc_after_branch", bus.pc_out, 32'h104);
    bus.pc_inc = 1'b0;

    // Link register write pulse
    bus.c_we = 1'b1; bus.c_addr = 4'd14; bus.c_data = 32'h20;
    tick();
    chk("lr_pulse", DW'(bus.lr_written), 32'h1);
    bus.c_we = 1'b0; bus.b_addr = 4'd14;
    #1 chk("read_r14", bus.b_data, 32'h20);
    tick();
    chk("lr_pulse_end", DW'(bus.lr_written), 32'h0);
    bus.c_we = 1'b1; bus.c_addr = 4'd13; bus.c_data = 32'h5;
    tick();
    chk("lr_r13", DW'(bus.lr_written), 32'h0);
    bus.c_we = 1'b0;

    // Same address on both ports, including bypass
    bus.a_addr = 4'd7; bus.b_addr = 4'd7; bus.c_we = 1'b1; bus.c_addr = 4'd7; bus.c_data = 32'hA5A5_0001;
    #1 chk("dual_a", bus.a_data, 32'hA5A5_0001);
    chk("dual_b", bus.b_data, 32'hA5A5_0001);
    tick();
    bus.c_we = 1'b0;

    // PC wrap
    bus.c_we = 1'b1; bus.c_addr = 4'd15; bus.c_data = 32'hFFFF_FFFC;
    tick();
    bus.c_we = 1'b0; bus.pc_inc = 1'b1;
    tick();
    chk("pc_wrap", bus.pc_out, 32'h0);
    bus.pc_inc = 1'b0;

    // Asynchronous reset between edges
    bus.c_we = 1'b1; bus.c_addr = 4'd5; bus.c_data = 32'd7;
    tick();
    bus.c_we = 1'b0; bus.a_addr = 4'd5; bus.b_addr = 4'd3; bus.pc_inc = 1'b1;
    #1 chk("r5_before_reset", bus.a_data, 32'd7);
    #1 reset = 1'b1;
    #1 chk("r5_async_reset", bus.a_data, 32'h0);
    chk("r3_async_reset", bus.b_data, 32'h0);
    chk("pc_async_reset", bus.pc_out, 32'h0);
    bus.pc_inc = 1'b0;
    tick();
    reset = 1'b0;
    bus.c_we = 1'b1; bus.c_addr = 4'd9; bus.c_data = 32'h1234;
    tick();
    bus.c_we = 1'b0; bus.a_addr = 4'd9;
    #1 chk("first_edge_after_reset", bus.a_data, 32'h1234);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/register_file_c.md
Name: register_file_c

Overview:
- Register file that receives the destination address chosen by the C-port selector (rd, R14 link, R15 PC, or other IR fields) and commits write-back data to that register.
- Provides two combinational read ports (A, B) for the ALU operand path.
- Owns R15 as the program counter, with a per-cycle increment.
- Sits between the datapath write-back bus and the operand multiplexers.

Parameters:
- DATA_W, 32, width of every register and data port
- PC_STEP, 4, value added to R15 when pc_inc is asserted
- RESET_PC, 0, value loaded into R15 on reset

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- c_addr  input  4  destination register index from the C selector
- c_data  input  DATA_W  write-back data
- c_we  input  1  write enable for the C port
- a_addr  input  4  read port A index
- b_addr  input  4  read port B index
- pc_inc  input  1  advance R15 by PC_STEP this cycle
- a_data  output  DATA_W  read port A data
- b_data  output  DATA_W  read port B data
- pc_out  output  DATA_W  current R15 value, registered
- lr_written  output  1  pulses high for one cycle after a commit to R14

Behaviour:
- Storage: 16 registers, R0..R15; all are general purpose except R15.
- Reset, asynchronous while reset=1:
  - R0..R14 = 0; R15 = RESET_PC.
  - lr_written = 0.
  - a_data and b_data reflect the reset contents; pc_out = RESET_PC.
- Write: on a rising clk edge with c_we=1, reg[c_addr] <= c_data. The value is visible in storage the next cycle.
- R15 update priority at each clk edge, highest first:
  1. c_we=1 and c_addr=15: R15 <= c_data. A branch or link-load overrides increment, so pc_inc is ignored.
  2. otherwise pc_inc=1: R15 <= R15 + PC_STEP, modulo 2^DATA_W; wraps from all-ones to the low value with no flag.
  3. otherwise: R15 holds.
- Reads are combinational with write-through bypass:
  - If c_we=1 and a_addr==c_addr, a_data = c_data; otherwise a_data = reg[a_addr]. Port B follows the same rule with b_addr.
  - Bypass applies to R15 as well: a pending PC write is forwarded.
  - The pc_inc result is not forwarded; a read of R15 returns the pre-increment value in the same cycle.
  - a_addr==b_addr is legal; both ports return identical data.
- pc_out is always the stored R15 and is never bypassed.
- lr_written: registered; set to 1 on the edge that commits c_addr=14 with c_we=1, and 0 on every other edge.
- c_we=0: no register changes other than the R15 increment; c_addr and c_data are don't-care.
- Reset asserted mid-cycle: all state clears immediately. A write pending at that edge is discarded.
- After reset deasserts, the first edge behaves normally.
- No X propagation: every c_addr value is legal, and decode covers all 16 indices.

Decomposition:
- Shared package regfile_pkg:
  - REG_IDX_W = 4
  - REG_LR = 4'd14
  - REG_PC = 4'd15
  - DATA_W default
  - These constants are shared with the C selector, whose constant inputs 4'b1110 and 4'b1111 must come from REG_LR and REG_PC.
- Sub-module dec4to16: combinational one-hot decode of c_addr gated by c_we, producing per-register write enables. The top instantiates it once.
- Storage, the R15 priority logic and the bypass muxes stay in the top.

Test Plan:
- Reset with reset=1 for 2 cycles → a_data=b_data=0 for any address; pc_out=RESET_PC=0; lr_written=0.
- Write c_addr=3, c_data=32'hDEADBEEF, c_we=1, a_addr=3 in the same cycle → a_data=32'hDEADBEEF through the bypass; the next cycle with c_we=0 still reads 32'hDEADBEEF.
- pc_inc=1 for 3 edges from reset → pc_out = 4, 8, 12; a_addr=15 reads 12 after the third edge.
- Same edge: pc_inc=1, c_we=1, c_addr=15, c_data=32'h100 → pc_out=32'h100, not 32'h104; the next pc_inc edge gives 32'h104.
- Write c_addr=14, c_data=32'h20 → lr_written=1 for exactly one cycle after the edge; b_addr=14 reads 32'h20. A write to c_addr=13 leaves lr_written=0.
- Load R15=32'hFFFFFFFC, then pc_inc=1 → pc_out=0 (wrap). Then assert reset between clock edges after writing R5=7 → R5 reads 0 immediately, before the next edge.
